// File: rtl/lc3b_types.sv
// Shared types for the L2 eviction buffer: block type, state encoding and
// address split constants. Optional feature macro: L2_EVB_FORWARD_EN.
package lc3b_types;

  typedef logic [127:0] lc3b_block;

  localparam int ADDR_W            = 16;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int TAG_W             = ADDR_W - BLOCK_OFFSET_BITS;

  typedef logic [TAG_W-1:0] evb_tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } evb_state_t;

  // Rebuild a block-aligned memory address from a tag.
  function automatic logic [ADDR_W-1:0] block_addr(input evb_tag_t tag);
    return {tag, {BLOCK_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_evict_fifo.sv
// Circular FIFO of evicted blocks with a parallel tag lookup and an in-place
// overwrite port used to coalesce repeated evictions of the same block.
module l2_evict_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH     = 2,
  parameter int LOG_DEPTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  evb_tag_t           lookup_tag,
  output logic               hit,
  output lc3b_block          hit_data,
  input  logic               push,
  input  evb_tag_t           push_tag,
  input  lc3b_block          push_data,
  input  logic               ovw,
  input  lc3b_block          ovw_data,
  input  logic               pop,
  output evb_tag_t           head_tag,
  output lc3b_block          head_data,
  output logic [LOG_DEPTH:0] count,
  output logic               full
);

  logic                 valid_q [DEPTH];
  logic                 valid_d [DEPTH];
  evb_tag_t             tag_q   [DEPTH];
  evb_tag_t             tag_d   [DEPTH];
  lc3b_block            data_q  [DEPTH];
  lc3b_block            data_d  [DEPTH];
  logic [LOG_DEPTH-1:0] head_q, head_d;
  logic [LOG_DEPTH-1:0] tail_q, tail_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic [LOG_DEPTH-1:0] hit_idx;

  // Parallel tag compare; coalescing keeps at most one entry matching.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == lookup_tag)) begin
        hit     = 1'b1;
        hit_idx = LOG_DEPTH'(i);
      end
    end
  end

  assign hit_data  = data_q[hit_idx];
  assign head_tag  = tag_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;
  assign full      = (count_q == (LOG_DEPTH+1)'(DEPTH));

  // Next-state for entries and pointers: push at tail, overwrite on hit, pop at head.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tag_d[tail_q]   = push_tag;
      data_d[tail_q]  = push_data;
      tail_d          = tail_q + LOG_DEPTH'(1);
      count_d         = count_q + (LOG_DEPTH+1)'(1);
    end
    if (ovw) begin
      data_d[hit_idx] = ovw_data;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + LOG_DEPTH'(1);
      count_d         = count_q - (LOG_DEPTH+1)'(1);
    end
  end

  // Control state: valid bits and pointers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload: meaningful only where valid is set, so no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/l2_evict_buffer.sv
// Write-back eviction buffer between L2 and physical memory. Absorbs dirty
// evictions, forwards read misses, drains buffered blocks when idle.
// Optional feature macro: L2_EVB_FORWARD_EN (serve read hits from the buffer;
// when undefined, a matching read first drains until no entry matches).
module l2_evict_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH     = 2,
  parameter int LOG_DEPTH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  lc3b_block   mem_wdata,
  output lc3b_block   mem_rdata,
  output logic        mem_resp,
  output logic [15:0] pmem_address,
  output lc3b_block   pmem_wdata,
  output logic        pmem_read,
  output logic        pmem_write,
  input  lc3b_block   pmem_rdata,
  input  logic        pmem_resp
);

  evb_state_t         state_q, state_d;
  evb_tag_t           addr_q, addr_d;
  lc3b_block          mem_rdata_q, mem_rdata_d;
  logic               mem_resp_q, mem_resp_d;
  logic [15:0]        pmem_address_q, pmem_address_d;
  lc3b_block          pmem_wdata_q, pmem_wdata_d;
  logic               pmem_read_q, pmem_read_d;
  logic               pmem_write_q, pmem_write_d;

  evb_tag_t           req_tag;
  logic               hit;
  lc3b_block          hit_data;
  logic               push, ovw, pop;
  evb_tag_t           head_tag;
  lc3b_block          head_data;
  logic [LOG_DEPTH:0] count;
  logic               full;
  logic               unused_offset;

  assign req_tag       = mem_address[15:BLOCK_OFFSET_BITS];
  assign unused_offset = ^mem_address[BLOCK_OFFSET_BITS-1:0];

  l2_evict_fifo #(
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .lookup_tag (req_tag),
    .hit        (hit),
    .hit_data   (hit_data),
    .push       (push),
    .push_tag   (req_tag),
    .push_data  (mem_wdata),
    .ovw        (ovw),
    .ovw_data   (mem_wdata),
    .pop        (pop),
    .head_tag   (head_tag),
    .head_data  (head_data),
    .count      (count),
    .full       (full)
  );

  // Next state and next registered outputs; strobes default low each cycle.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    mem_rdata_d    = mem_rdata_q;
    mem_resp_d     = 1'b0;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    pmem_read_d    = 1'b0;
    pmem_write_d   = 1'b0;
    push           = 1'b0;
    ovw            = 1'b0;
    pop            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read) begin
`ifdef L2_EVB_FORWARD_EN
          if (hit) begin
            mem_rdata_d = hit_data;
            mem_resp_d  = 1'b1;
            state_d     = RESP;
          end else begin
            addr_d         = req_tag;
            pmem_address_d = block_addr(req_tag);
            pmem_read_d    = 1'b1;
            state_d        = READ;
          end
`else
          if (hit) begin
            pmem_address_d = block_addr(head_tag);
            pmem_wdata_d   = head_data;
            pmem_write_d   = 1'b1;
            state_d        = DRAIN;
          end else begin
            addr_d         = req_tag;
            pmem_address_d = block_addr(req_tag);
            pmem_read_d    = 1'b1;
            state_d        = READ;
          end
`endif
        end else if (mem_write && hit) begin
          ovw        = 1'b1;
          mem_resp_d = 1'b1;
          state_d    = RESP;
        end else if (mem_write && !full) begin
          push       = 1'b1;
          mem_resp_d = 1'b1;
          state_d    = RESP;
        end else if (mem_write || (count != '0)) begin
          pmem_address_d = block_addr(head_tag);
          pmem_wdata_d   = head_data;
          pmem_write_d   = 1'b1;
          state_d        = DRAIN;
        end
      end
      READ: begin
        if (pmem_resp) begin
          mem_rdata_d = pmem_rdata;
          mem_resp_d  = 1'b1;
          state_d     = RESP;
        end else begin
          pmem_read_d = 1'b1;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else begin
          pmem_write_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything visible upstream and downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_rdata_q    <= '0;
      mem_resp_q     <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_rdata_q    <= mem_rdata_d;
      mem_resp_q     <= mem_resp_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
    end
  end

  // Latched read-miss tag; only consumed while in READ.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign mem_rdata    = mem_rdata_q;
  assign mem_resp     = mem_resp_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;

endmodule

// File: tb/tb_l2_evict_buffer.sv
// Bench for l2_evict_buffer: directed requests, a 3-cycle memory model,
// and scoreboard queues for upstream responses and downstream strobes.
// Expectations follow L2_EVB_FORWARD_EN when it is defined.
module tb_l2_evict_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_read, pmem_write, pmem_resp;

  always #5 clk = ~clk;

  l2_evict_buffer #(.DEPTH(2), .LOG_DEPTH(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_presp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit wr; logic [15:0] addr; logic [127:0] data; } pev_t;
  typedef struct { bit is_rd; logic [127:0] data; } rsp_t;

  pev_t         exp_pmem[$];
  rsp_t         exp_rsp[$];
  logic [127:0] mem [logic [15:0]];

  function automatic logic [127:0] dflt(input logic [15:0] a);
    return {8{a}};
  endfunction

  function automatic logic [127:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_w(input logic [15:0] a, input logic [127:0] d);
    pev_t e;
    e.wr = 1'b1; e.addr = a; e.data = d;
    exp_pmem.push_back(e);
  endtask

  task automatic exp_r(input logic [15:0] a);
    pev_t e;
    e.wr = 1'b0; e.addr = a; e.data = '0;
    exp_pmem.push_back(e);
  endtask

  // Memory model: responds 3 cycles after a strobe first appears; checks each strobe.
  initial begin : pmem_model
    bit   active;
    int   cnt;
    pev_t e;
    active = 1'b0; cnt = 0; pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if ((pmem_read || pmem_write) && !reset) begin
        if (!active) begin
          active = 1'b1; cnt = 0;
          checks++;
          if (exp_pmem.size() == 0) begin
            errors++;
            $display("FAIL pmem_event: got rd=%0d wr=%0d addr=%h expected no access",
                     pmem_read, pmem_write, pmem_address);
          end else begin
            e = exp_pmem.pop_front();
            if ((pmem_read && pmem_write) || (pmem_write !== e.wr) ||
                (pmem_address !== e.addr) || (e.wr && (pmem_wdata !== e.data))) begin
              errors++;
              $display("FAIL pmem_event: got rd=%0d wr=%0d addr=%h data=%h expected wr=%0d addr=%h data=%h",
                       pmem_read, pmem_write, pmem_address, pmem_wdata, e.wr, e.addr, e.data);
            end
          end
        end else begin
          cnt++;
          if (cnt == 2) begin
            pmem_resp = 1'b1;
            last_presp_cyc = cyc;
            if (pmem_write) mem[pmem_address] = pmem_wdata;
            else            pmem_rdata = mem_rd(pmem_address);
            active = 1'b0;
          end
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  // Response monitor: every mem_resp pulse consumes one expected response.
  initial begin : rsp_mon
    rsp_t r;
    forever begin
      @(negedge clk);
      if (mem_resp) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL mem_resp: got unexpected pulse expected none");
        end else begin
          r = exp_rsp.pop_front();
          if (r.is_rd && (mem_rdata !== r.data)) begin
            errors++;
            $display("FAIL mem_rdata: got %h expected %h", mem_rdata, r.data);
          end
        end
      end
    end
  end

  // Issue one request from a negedge and hold it until mem_resp is seen.
  task automatic req(input bit rd, input bit wr, input logic [15:0] a,
                     input logic [127:0] d, input logic [127:0] exp_rd, output int lat);
    rsp_t r;
    r.is_rd = rd; r.data = exp_rd;
    exp_rsp.push_back(r);
    mem_address = a; mem_read = rd; mem_write = wr; mem_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_resp && lat < 200);
    if (!mem_resp) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no mem_resp expected one for addr %h", a);
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n;
    n = 0;
    while (!(dut.state_q == lc3b_types::IDLE && dut.u_fifo.count_q == 0 &&
             !pmem_read && !pmem_write) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, (n < 300), 1);
    check({name, "_pmem_left"}, exp_pmem.size(), 0);
  endtask

  logic [127:0] va, vb, vc, vd, ve1, ve2, ve3, vf, vg;
  int lat, rcyc, n;

  initial begin
    va  = {4{32'hAAAA_0001}}; vb  = {4{32'hBBBB_0002}}; vc  = {4{32'hCCCC_0003}};
    vd  = {4{32'hDDDD_0004}}; ve1 = {4{32'hE1E1_0005}}; ve2 = {4{32'hE2E2_0006}};
    ve3 = {4{32'hE3E3_0007}}; vf  = {4{32'hF0F0_0008}}; vg  = {4{32'h6666_0009}};
    reset = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_resp", mem_resp, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // Two writes back to back, then idle: FIFO-order drain.
    exp_w(16'h1230, va); exp_w(16'h4560, vb);
    req(0, 1, 16'h1230, va, '0, lat);
    check("wr1_lat", lat, 1);
    check("wr1_count", dut.u_fifo.count_q, 1);
    req(0, 1, 16'h4560, vb, '0, lat);
    check("wr2_lat", lat, 2);
    check("wr2_count", dut.u_fifo.count_q, 2);
    wait_drained("t1");
    check("t1_mem_a", mem_rd(16'h1230), va);
    check("t1_mem_b", mem_rd(16'h4560), vb);

    // Read of a block that is still buffered.
`ifdef L2_EVB_FORWARD_EN
    exp_w(16'h2000, vc);
`else
    exp_w(16'h2000, vc); exp_r(16'h2000);
`endif
    req(0, 1, 16'h2000, vc, '0, lat);
    check("wr_c_lat", lat, 1);
    req(1, 0, 16'h2008, '0, vc, lat);
`ifdef L2_EVB_FORWARD_EN
    check("fwd_lat", lat, 2);
`endif
    wait_drained("t2");

    // Full buffer forces a drain, then a coalescing write.
    exp_w(16'h0100, ve1); exp_w(16'h0200, vd); exp_w(16'h0300, ve3);
    req(0, 1, 16'h0100, ve1, '0, lat);
    check("fill1_lat", lat, 1);
    req(0, 1, 16'h0200, ve2, '0, lat);
    check("fill2_count", dut.u_fifo.count_q, 2);
    req(0, 1, 16'h0300, ve3, '0, lat);
    check("full_wr_count", dut.u_fifo.count_q, 2);
    req(0, 1, 16'h0200, vd, '0, lat);
    check("coalesce_lat", lat, 2);
    check("coalesce_count", dut.u_fifo.count_q, 2);
    wait_drained("t3");
    check("t3_mem_d", mem_rd(16'h0200), vd);
    check("t3_mem_e3", mem_rd(16'h0300), ve3);

    // Read miss takes priority over draining another buffered block.
    exp_r(16'h7770); exp_w(16'h5550, vf);
    req(0, 1, 16'h5550, vf, '0, lat);
    check("wr_f_lat", lat, 1);
    req(1, 0, 16'h7770, '0, dflt(16'h7770), lat);
    rcyc = cyc;
    check("rdmiss_resp_delay", rcyc - last_presp_cyc, 1);
    wait_drained("t4");

    // Reset in the middle of a drain discards the buffered block.
    exp_w(16'h6660, vg);
    req(0, 1, 16'h6660, vg, '0, lat);
    check("wr_g_lat", lat, 1);
    n = 0;
    while (!pmem_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_started", pmem_write, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_drain_pmem_write", pmem_write, 0);
    check("rst_drain_count", dut.u_fifo.count_q, 0);
    check("rst_drain_mem_resp", mem_resp, 0);
    exp_r(16'h6660);
    req(1, 0, 16'h6660, '0, dflt(16'h6660), lat);
    wait_drained("t5");

    repeat (3) @(negedge clk);
    check("rsp_left", exp_rsp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
